// File: rtl/operand_fetch.sv
// Operand fetch stage: 32-entry register file, pending-write scoreboard and a one-deep output register.
// Define OPF_BYPASS_EN to forward same-cycle writeback data into operand reads and hazard checks.
module operand_fetch #(
   parameter int DW = 32,
   parameter int IW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [IW-1:0] in_inst,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_r1,
   output logic [DW-1:0] out_r2,
   output logic [IW-1:0] out_inst,
   input  logic          wb_en,
   input  logic [4:0]    wb_rd,
   input  logic [DW-1:0] wb_data
);

   localparam logic [6:0] OP_ALU  = 7'h33;
   localparam logic [6:0] OP_ALUI = 7'h13;

   logic [DW-1:0] rf [32];
   logic [31:0]   pending;
   logic [31:0]   pend_eff;
   logic [31:0]   wb_hit;
   logic [31:0]   set_mask;
   logic [4:0]    rs1;
   logic [4:0]    rs2;
   logic [4:0]    out_rd;
   logic [6:0]    opcode;
   logic [6:0]    out_op;
   logic [DW-1:0] rd1;
   logic [DW-1:0] rd2;
   logic          stall;
   logic          accept;
   logic          out_hs;

   assign rs1    = in_inst[19:15];
   assign rs2    = in_inst[24:20];
   assign opcode = in_inst[6:0];
   assign out_rd = out_inst[11:7];
   assign out_op = out_inst[6:0];

   assign wb_hit = (wb_en && (wb_rd != 5'd0)) ? (32'd1 << wb_rd) : 32'd0;

`ifdef OPF_BYPASS_EN
   // A writeback landing this cycle resolves its hazard immediately.
   assign pend_eff = pending & ~wb_hit;

   always_comb begin
      rd1 = rf[rs1];
      rd2 = rf[rs2];
      if ((rs1 != 5'd0) && wb_hit[rs1]) rd1 = wb_data;
      if ((rs2 != 5'd0) && wb_hit[rs2]) rd2 = wb_data;
   end
`else
   assign pend_eff = pending;

   always_comb begin
      rd1 = rf[rs1];
      rd2 = rf[rs2];
   end
`endif

   assign stall = in_valid &&
                  (((rs1 != 5'd0) && pend_eff[rs1]) ||
                   ((opcode == OP_ALU) && (rs2 != 5'd0) && pend_eff[rs2]));

   assign in_ready = (!out_valid || out_ready) && !stall;
   assign accept   = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;

   assign set_mask = (out_hs && ((out_op == OP_ALU) || (out_op == OP_ALUI)) && (out_rd != 5'd0))
                     ? (32'd1 << out_rd) : 32'd0;

   // rf[0] is never written, so it always reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (wb_en && (wb_rd != 5'd0)) begin
         rf[wb_rd] <= wb_data;
      end
   end

   // Set wins over clear when both hit the same index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~wb_hit) | set_mask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_r1    <= '0;
         out_r2    <= '0;
         out_inst  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_r1    <= rd1;
         out_r2    <= rd2;
         out_inst  <= in_inst;
      end else if (!out_valid || out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
module tb_operand_fetch;

`ifdef OPF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_inst;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_r1;
   logic [31:0] out_r2;
   logic [31:0] out_inst;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int n_cmp  = 0;
   int n_fail = 0;

   operand_fetch #(.DW(32), .IW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_r1(out_r1), .out_r2(out_r2), .out_inst(out_inst),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural model: register values, outstanding writes, output slot.
   logic [31:0] m_rf [32];
   bit          m_pend [32];
   bit          m_ov;
   logic [31:0] m_r1, m_r2, m_inst;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin
         m_rf[i]   = 32'd0;
         m_pend[i] = 1'b0;
      end
      m_ov = 1'b0; m_r1 = 32'd0; m_r2 = 32'd0; m_inst = 32'd0;
   endtask

   function automatic bit busy(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      if (BYP && wb_en && wb_rd == r) return 1'b0;
      return m_pend[r];
   endfunction

   function automatic bit m_ready();
      bit st;
      st = in_valid && (busy(in_inst[19:15]) ||
                        (in_inst[6:0] == 7'h33 && busy(in_inst[24:20])));
      return (!m_ov || out_ready) && !st;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (BYP && wb_en && wb_rd == r) return wb_data;
      return m_rf[r];
   endfunction

   task automatic m_edge();
      bit acc, hs;
      logic [4:0] rd;
      acc = in_valid && m_ready();
      hs  = m_ov && out_ready;
      rd  = m_inst[11:7];
      if (wb_en && wb_rd != 5'd0) m_pend[wb_rd] = 1'b0;
      if (hs && (m_inst[6:0] == 7'h33 || m_inst[6:0] == 7'h13) && rd != 5'd0) m_pend[rd] = 1'b1;
      if (acc) begin
         m_r1   = m_read(in_inst[19:15]);
         m_r2   = m_read(in_inst[24:20]);
         m_inst = in_inst;
         m_ov   = 1'b1;
      end else if (!m_ov || out_ready) begin
         m_ov = 1'b0;
      end
      if (wb_en && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", in_ready, m_ready());
         chk("out_valid", out_valid, m_ov);
         if (m_ov) begin
            chk("out_r1", out_r1, m_r1);
            chk("out_r2", out_r2, m_r2);
            chk("out_inst", out_inst, m_inst);
         end
      end
   end

   task automatic drive(input bit iv, input logic [31:0] inst, input bit ordy,
                        input bit we, input logic [4:0] wrd, input logic [31:0] wd);
      in_valid = iv; in_inst = inst; out_ready = ordy;
      wb_en = we; wb_rd = wrd; wb_data = wd;
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) m_edge();
      #1;
   endtask

   function automatic logic [31:0] rnd_inst();
      logic [31:0] w;
      w = $urandom;
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      w[11:7]  = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
         0, 1: w[6:0] = 7'h33;
         2:    w[6:0] = 7'h13;
         3:    w[6:0] = 7'h03;
         default: w[6:0] = 7'($urandom);
      endcase
      return w;
   endfunction

   initial begin
      m_reset();
      rst_n = 1'b0;
      drive(0, 32'd0, 0, 0, 5'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // First cycle after reset: ready, and x5 written while addi x1,x0,1 is accepted.
      drive(1, 32'h00100093, 1, 1, 5'd5, 32'h0000_00AA);
      #1 chk("ready_after_reset", in_ready, 1'b1);
      cyc();
      drive(1, 32'h000283B3, 1, 0, 5'd0, 32'd0);
      cyc();
      chk("add_x7_valid", out_valid, 1'b1);
      chk("add_x7_r1", out_r1, 32'h0000_00AA);
      chk("add_x7_r2", out_r2, 32'd0);
      drive(0, 32'd0, 1, 0, 5'd0, 32'd0);
      cyc();

      // addi x8,x7,1 waits on x7.
      drive(1, 32'h00138413, 1, 0, 5'd0, 32'd0);
      #1 chk("raw_stall0", in_ready, 1'b0);
      cyc();
      chk("raw_stall1", in_ready, 1'b0);
      cyc();
      drive(1, 32'h00138413, 1, 1, 5'd7, 32'h0000_1234);
      #1 chk("raw_wb_cycle_ready", in_ready, BYP);
      cyc();
      if (BYP) begin
         chk("raw_bypass_r1", out_r1, 32'h0000_1234);
      end else begin
         drive(1, 32'h00138413, 1, 0, 5'd0, 32'd0);
         #1 chk("raw_next_ready", in_ready, 1'b1);
         cyc();
         chk("raw_commit_r1", out_r1, 32'h0000_1234);
      end
      drive(0, 32'd0, 1, 0, 5'd0, 32'd0);
      cyc(); cyc();

      // Backpressure: output held for 4 cycles, then back-to-back accepts.
      drive(1, 32'h00028533, 0, 0, 5'd0, 32'd0);
      cyc();
      drive(1, 32'h0002A583, 0, 0, 5'd0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         #1 chk("hold_ready", in_ready, 1'b0);
         chk("hold_inst", out_inst, 32'h00028533);
         chk("hold_r1", out_r1, 32'h0000_00AA);
         cyc();
      end
      drive(1, 32'h0002A583, 1, 0, 5'd0, 32'd0);
      #1 chk("release_ready", in_ready, 1'b1);
      cyc();
      chk("b2b_inst0", out_inst, 32'h0002A583);
      drive(1, 32'h00100093, 1, 0, 5'd0, 32'd0);
      cyc();
      chk("b2b_inst1", out_inst, 32'h00100093);

      // x0: writes ignored, reads zero, never pending.
      drive(1, 32'h00000633, 1, 1, 5'd0, 32'hFFFF_FFFF);
      cyc();
      chk("x0_r1", out_r1, 32'd0);
      chk("x0_r2", out_r2, 32'd0);
      drive(1, 32'h00528033, 1, 0, 5'd0, 32'd0);
      cyc();
      drive(0, 32'd0, 1, 0, 5'd0, 32'd0);
      cyc();
      drive(1, 32'h00000633, 1, 0, 5'd0, 32'd0);
      #1 chk("x0_no_pending", in_ready, 1'b1);
      cyc();
      drive(0, 32'd0, 1, 0, 5'd0, 32'd0);
      cyc();

      // Handshake setting pending[9] while x9 is written back: set wins.
      drive(1, 32'h000284B3, 1, 0, 5'd0, 32'd0);
      cyc();
      drive(0, 32'd0, 1, 1, 5'd9, 32'h0000_0055);
      cyc();
      drive(1, 32'h00048693, 1, 0, 5'd0, 32'd0);
      #1 chk("set_clear_stall0", in_ready, 1'b0);
      cyc();
      chk("set_clear_stall1", in_ready, 1'b0);
      drive(1, 32'h00048693, 1, 1, 5'd9, 32'h0000_0066);
      cyc();
      drive(0, 32'd0, 1, 0, 5'd0, 32'd0);
      cyc(); cyc();

      // Async reset with a valid output and outstanding pending bits.
      drive(1, 32'h00028733, 1, 0, 5'd0, 32'd0);
      cyc();
      drive(1, 32'h000287B3, 1, 0, 5'd0, 32'd0);
      cyc();
      drive(0, 32'd0, 0, 0, 5'd0, 32'd0);
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_out_r1", out_r1, 32'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      drive(1, 32'h00570833, 1, 0, 5'd0, 32'd0);
      #1 chk("rst_pending_clear", in_ready, 1'b1);
      cyc();
      chk("rst_x5_zero", out_r2, 32'd0);
      chk("rst_after_valid", out_valid, 1'b1);

      // Randomized traffic checked by the negedge compare process.
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 9) < 7, rnd_inst(), $urandom_range(0, 3) != 0,
               $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom);
         cyc();
      end

      drive(0, 32'd0, 1, 0, 5'd0, 32'd0);
      cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
